// File: rtl/ram_mmio_responder_pkg.sv
// Shared constants for the minicpu data-RAM responder.
// Covers the MMIO register addresses, CONS_STAT bit positions and the address-window decode.
package ram_mmio_responder_pkg;

  localparam logic [7:0] MMIO_BASE   = 8'hF0;
  localparam logic [7:0] CONS_DATA_A = 8'hFC;
  localparam logic [7:0] CONS_STAT_A = 8'hFD;
  localparam logic [7:0] CYC_LO_A    = 8'hFE;
  localparam logic [7:0] HALT_A      = 8'hFF;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 4;

  localparam int CYC_W = 16;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_RSVD,
    SEL_CONS_DATA,
    SEL_CONS_STAT,
    SEL_CYC_LO,
    SEL_HALT
  } sel_e;

  // The MMIO window is always the top 16 addresses, so only the low nibble picks the register.
  function automatic sel_e decode_sel(input logic in_mmio, input logic [3:0] off);
    if (!in_mmio) return SEL_RAM;
    case (off)
      CONS_DATA_A[3:0]: return SEL_CONS_DATA;
      CONS_STAT_A[3:0]: return SEL_CONS_STAT;
      CYC_LO_A[3:0]:    return SEL_CYC_LO;
      HALT_A[3:0]:      return SEL_HALT;
      default:          return SEL_RSVD;
    endcase
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO for console bytes; a push becomes visible at the head one cycle later (no fall-through).
// A push while full is taken only when a pop shares the same edge; otherwise it is refused.
module console_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_W-1:0]      head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_mmio_responder.sv
// minicpu data-RAM bus responder: RAM below a top-16 MMIO window (console FIFO, status, cycle count, halt).
// Reads are combinational, writes commit on the strobed edge; console pushes into a full FIFO are dropped and flagged.
module ram_mmio_responder
  import ram_mmio_responder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              rd_,
  input  logic              wr_,
  output logic [DATA_W-1:0] cons_data,
  output logic              cons_valid,
  input  logic              cons_ready,
  output logic              halt
);

  localparam int RAM_SIZE = 2**ADDR_W - 16;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] ram [RAM_SIZE];

  sel_e              sel;
  logic              in_mmio;
  logic              rd_en;
  logic              wr_en;
  logic              cons_push;
  logic              cons_pop;
  logic              push_drop;
  logic              stat_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [7:0]        cyc_lo;
  logic [7:0]        stat;
  logic [DATA_W-1:0] rd_val;

  assign in_mmio = &addr[ADDR_W-1:4];
  assign sel     = decode_sel(in_mmio, addr[3:0]);
  assign rd_en   = ~rd_;
  assign wr_en   = ~wr_;

  assign cons_push  = wr_en & (sel == SEL_CONS_DATA);
  assign cons_valid = ~fifo_empty;
  assign cons_pop   = cons_valid & cons_ready;
  assign push_drop  = cons_push & fifo_full & ~cons_pop;
  assign stat_rd    = rd_en & (sel == SEL_CONS_STAT);

  console_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cons_push),
    .push_data (d_in),
    .pop       (cons_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (cons_data)
  );

  always_ff @(posedge clk) begin
    if (wr_en && sel == SEL_RAM) ram[addr] <= d_in;
  end

  // A dropped push outranks the clear-on-read so an overflow is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (push_drop) overflow <= 1'b1;
    else if (stat_rd)   overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           halt <= 1'b0;
    else if (wr_en && sel == SEL_HALT) halt <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cyc_cnt <= '0;
    else if (!halt) cyc_cnt <= cyc_cnt + CYC_W'(1);
  end

  assign cyc_lo = 8'(cyc_cnt);

  always_comb begin
    stat                       = '0;
    stat[STAT_FULL_BIT]        = fifo_full;
    stat[STAT_EMPTY_BIT]       = fifo_empty;
    stat[STAT_OVF_BIT]         = overflow;
    stat[STAT_CNT_LSB +: 4]    = 4'(fifo_count);
  end

  // Simultaneous rd_/wr_ naturally returns the pre-write value: RAM and registers update only at the edge.
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_RAM:       rd_val = ram[addr];
      SEL_CONS_STAT: rd_val = DATA_W'(stat);
      SEL_CYC_LO:    rd_val = DATA_W'(cyc_lo);
      SEL_HALT:      rd_val = DATA_W'(halt);
      default:       rd_val = '0;
    endcase
    d_out = rd_en ? rd_val : '0;
  end

endmodule

// File: tb/tb_ram_mmio_responder.sv
// Bench for ram_mmio_responder: directed vector table, hand-written halt/reset sequences,
// and randomized bus traffic checked against a queue-based reference model.
module tb_ram_mmio_responder;
  import ram_mmio_responder_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       rd_ = 1'b1;
  logic       wr_ = 1'b1;
  logic [7:0] cons_data;
  logic       cons_valid;
  logic       cons_ready = 1'b0;
  logic       halt;

  ram_mmio_responder #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .d_in       (d_in),
    .d_out      (d_out),
    .rd_        (rd_),
    .wr_        (wr_),
    .cons_data  (cons_data),
    .cons_valid (cons_valid),
    .cons_ready (cons_ready),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%02h expected=%02h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: RAM image, console queue, sticky flags, free-running counter.
  logic [7:0]  m_ram [256];
  bit          m_ram_ok [256];
  logic [7:0]  q [$];
  bit          m_ovf = 1'b0;
  bit          m_halt = 1'b0;
  int unsigned m_cyc = 0;

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_halt = 1'b0;
    m_cyc  = 0;
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a, output bit known);
    known = 1'b1;
    if (a < MMIO_BASE) begin
      known = m_ram_ok[a];
      return m_ram[a];
    end
    if (a == CONS_STAT_A)
      return {4'(q.size()), 1'b0, m_ovf, q.size() == 0, q.size() == FIFO_DEPTH};
    if (a == CYC_LO_A) return 8'(m_cyc);
    if (a == HALT_A)   return {7'b0, m_halt};
    return 8'h00;
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [7:0] a,
                            input logic [7:0] d, input logic rdy);
    bit pop;
    bit push;
    bit dropped;
    pop     = (q.size() != 0) && rdy;
    push    = !w && (a == CONS_DATA_A);
    dropped = push && (q.size() == FIFO_DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !dropped) q.push_back(d);
    if (dropped) m_ovf = 1'b1;
    else if (!r && a == CONS_STAT_A) m_ovf = 1'b0;
    if (!w && a < MMIO_BASE) begin
      m_ram[a]    = d;
      m_ram_ok[a] = 1'b1;
    end
    if (!m_halt) m_cyc = (m_cyc + 1) & 32'hFFFF;
    if (!w && a == HALT_A) m_halt = 1'b1;
  endtask

  typedef struct packed {
    logic [7:0] dout;
    logic       vld;
    logic [7:0] cdata;
    logic       hlt;
  } smp_t;

  // One bus cycle: drive, sample mid-cycle, compare with the model, then advance through the edge.
  task automatic do_cycle(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic rdy, output smp_t s);
    bit         known;
    logic [7:0] exp_d;
    rd_ = r; wr_ = w; addr = a; d_in = d; cons_ready = rdy;
    #2;
    s.dout = d_out; s.vld = cons_valid; s.cdata = cons_data; s.hlt = halt;
    exp_d = model_rd(a, known);
    if (r)          chk("idle d_out", s.dout, 8'h00);
    else if (known) chk($sformatf("model d_out @%02h", a), s.dout, exp_d);
    chk("model cons_valid", 8'(s.vld), 8'(q.size() != 0));
    chk("model cons_data", s.cdata, (q.size() != 0) ? q[0] : 8'h00);
    chk("model halt", 8'(s.hlt), 8'(m_halt));
    model_edge(r, w, a, d, rdy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rn;
    logic       wn;
    logic [7:0] a;
    logic [7:0] d;
    logic       rdy;
    logic [7:0] e_dout;
    logic       e_vld;
    logic [7:0] e_cdata;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic wn, input logic [7:0] a, input logic [7:0] d,
                              input logic rdy, input logic [7:0] ed, input logic ev, input logic [7:0] ec);
    vec_t v;
    v.rn = rn; v.wn = wn; v.a = a; v.d = d; v.rdy = rdy;
    v.e_dout = ed; v.e_vld = ev; v.e_cdata = ec;
    return v;
  endfunction

  vec_t vecs [26];

  initial begin
    smp_t       s;
    logic [7:0] frozen;
    logic       r;
    logic       w;
    logic       rdy;
    logic [7:0] a;
    int         k;

    // RAM round-trip, reserved read, simultaneous strobes
    vecs[0]  = mk(1'b1, 1'b0, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[1]  = mk(1'b1, 1'b0, 8'hEF, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[2]  = mk(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h00);
    vecs[3]  = mk(1'b0, 1'b1, 8'hEF, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00);
    vecs[4]  = mk(1'b0, 1'b1, 8'hF3, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[5]  = mk(1'b1, 1'b0, 8'h20, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[6]  = mk(1'b0, 1'b0, 8'h20, 8'h22, 1'b0, 8'h11, 1'b0, 8'h00);
    vecs[7]  = mk(1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 8'h22, 1'b0, 8'h00);
    // console ordering
    vecs[8]  = mk(1'b1, 1'b0, CONS_DATA_A, 8'h41, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[9]  = mk(1'b1, 1'b0, CONS_DATA_A, 8'h42, 1'b0, 8'h00, 1'b1, 8'h41);
    vecs[10] = mk(1'b1, 1'b0, CONS_DATA_A, 8'h43, 1'b0, 8'h00, 1'b1, 8'h41);
    vecs[11] = mk(1'b0, 1'b1, CONS_STAT_A, 8'h00, 1'b0, 8'h30, 1'b1, 8'h41);
    vecs[12] = mk(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h41);
    vecs[13] = mk(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h42);
    vecs[14] = mk(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h43);
    vecs[15] = mk(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
    vecs[16] = mk(1'b0, 1'b1, CONS_STAT_A, 8'h00, 1'b0, 8'h02, 1'b0, 8'h00);
    // overflow, clear-on-read, push+pop while full
    vecs[17] = mk(1'b1, 1'b0, CONS_DATA_A, 8'h41, 1'b0, 8'h00, 1'b0, 8'h00);
    vecs[18] = mk(1'b1, 1'b0, CONS_DATA_A, 8'h42, 1'b0, 8'h00, 1'b1, 8'h41);
    vecs[19] = mk(1'b1, 1'b0, CONS_DATA_A, 8'h43, 1'b0, 8'h00, 1'b1, 8'h41);
    vecs[20] = mk(1'b1, 1'b0, CONS_DATA_A, 8'h44, 1'b0, 8'h00, 1'b1, 8'h41);
    vecs[21] = mk(1'b1, 1'b0, CONS_DATA_A, 8'h45, 1'b0, 8'h00, 1'b1, 8'h41);
    vecs[22] = mk(1'b0, 1'b1, CONS_STAT_A, 8'h00, 1'b0, 8'h45, 1'b1, 8'h41);
    vecs[23] = mk(1'b0, 1'b1, CONS_STAT_A, 8'h00, 1'b0, 8'h41, 1'b1, 8'h41);
    vecs[24] = mk(1'b1, 1'b0, CONS_DATA_A, 8'h46, 1'b1, 8'h00, 1'b1, 8'h41);
    vecs[25] = mk(1'b0, 1'b1, CONS_STAT_A, 8'h00, 1'b0, 8'h41, 1'b1, 8'h42);

    // reset state
    #12;
    chk("reset d_out idle", d_out, 8'h00);
    chk("reset cons_valid", 8'(cons_valid), 8'h00);
    chk("reset cons_data", cons_data, 8'h00);
    chk("reset halt", 8'(halt), 8'h00);
    rd_ = 1'b0; addr = CONS_STAT_A;
    #1;
    chk("reset CONS_STAT", d_out, 8'h02);
    addr = CYC_LO_A;
    #1;
    chk("reset CYC_LO", d_out, 8'h00);
    rd_ = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // cycle counter after ten edges
    repeat (10) do_cycle(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, s);
    do_cycle(1'b0, 1'b1, CYC_LO_A, 8'h00, 1'b0, s);
    chk("CYC_LO after 10 edges", s.dout, 8'h0A);

    for (int i = 0; i < 26; i++) begin
      do_cycle(vecs[i].rn, vecs[i].wn, vecs[i].a, vecs[i].d, vecs[i].rdy, s);
      chk($sformatf("vec%0d d_out", i), s.dout, vecs[i].e_dout);
      chk($sformatf("vec%0d cons_valid", i), 8'(s.vld), 8'(vecs[i].e_vld));
      chk($sformatf("vec%0d cons_data", i), s.cdata, vecs[i].e_cdata);
    end

    // random traffic (halt kept clear so the counter stays live)
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 4)      a = 8'($urandom_range(0, 31));
      else if (k == 5) a = 8'(MMIO_BASE + 8'($urandom_range(0, 11)));
      else if (k <= 7) a = CONS_DATA_A;
      else if (k == 8) a = CONS_STAT_A;
      else             a = CYC_LO_A;
      r   = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 4) < 2);
      do_cycle(r, w, a, 8'($urandom), rdy, s);
    end

    // halt: sticky, counter frozen afterwards
    do_cycle(1'b1, 1'b0, HALT_A, 8'h00, 1'b1, s);
    frozen = 8'(m_cyc);
    do_cycle(1'b0, 1'b1, HALT_A, 8'h00, 1'b1, s);
    chk("halt next cycle", 8'(s.hlt), 8'h01);
    chk("HALT reg read", s.dout, 8'h01);
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b0, 1'b1, CYC_LO_A, 8'h00, 1'b1, s);
      chk($sformatf("CYC_LO frozen %0d", i), s.dout, frozen);
    end

    // reset mid-operation with bytes queued and halt set
    do_cycle(1'b1, 1'b0, 8'h10, 8'h5A, 1'b1, s);
    repeat (6) do_cycle(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, s);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, CONS_DATA_A, 8'(8'h61 + i), 1'b0, s);
    chk("pre-reset cons_valid", 8'(cons_valid), 8'h01);
    chk("pre-reset cons_data", cons_data, 8'h61);
    rd_ = 1'b0; wr_ = 1'b1; addr = CYC_LO_A; cons_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid-reset cons_valid", 8'(cons_valid), 8'h00);
    chk("mid-reset halt", 8'(halt), 8'h00);
    chk("mid-reset CYC_LO", d_out, 8'h00);
    chk("mid-reset cons_data", cons_data, 8'h00);
    #1 rst = 1'b0;
    model_reset();
    do_cycle(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, s);
    chk("RAM kept across reset", s.dout, 8'h5A);
    do_cycle(1'b0, 1'b1, CYC_LO_A, 8'h00, 1'b0, s);
    chk("CYC_LO restarts", s.dout, 8'h01);
    do_cycle(1'b0, 1'b1, CONS_STAT_A, 8'h00, 1'b0, s);
    chk("CONS_STAT after reset", s.dout, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_mmio_responder.md
# ram_mmio_responder

Responder end of the minicpu data-RAM bus: it answers the `ram_rd_`/`ram_wr_` strobes the CPU issues and replaces the behavioural `ram` model in `test`. Addresses below the MMIO window hit a register-array RAM. The top 16 addresses form an MMIO window with a console output FIFO, a status register, a cycle counter and a halt register. Benches and the top level use `halt` to end simulation instead of watching ROM opcodes.

## Interface
- `ADDR_W`, 8: address width, equal to `AddrBus`.
- `DATA_W`, 8: data width, equal to `DataBus`.
- `FIFO_DEPTH`, 4: console FIFO entries; power of two, at least 2.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in `ADDR_W`: address from the CPU.
- `d_in` in `DATA_W`: write data from the CPU.
- `d_out` out `DATA_W`: read data to the CPU.
- `rd_` in 1: read strobe, active low.
- `wr_` in 1: write strobe, active low.
- `cons_data` out `DATA_W`: FIFO head byte.
- `cons_valid` out 1: FIFO not empty.
- `cons_ready` in 1: sink accepts the head byte.
- `halt` out 1: sticky program-done flag.

## Operation
- Address map:
  - 0x00–0xEF: RAM.
  - 0xF0–0xFB: reserved. Reads return 0; writes are ignored.
  - 0xFC CONS_DATA: a write pushes `d_in[7:0]`; a read returns 0.
  - 0xFD CONS_STAT: read-only. bit0 full, bit1 empty, bit2 overflow, bits[7:4] count.
  - 0xFE CYC_LO: read-only, low byte of the cycle counter.
  - 0xFF HALT: a write of any value sets `halt`; a read returns {7'b0, halt}.
- Reads are combinational. `d_out` = selected value while `rd_`=0, else 0.
- Writes commit at the rising edge where `wr_`=0.
- `rd_`=0 and `wr_`=0 together: the write commits at the edge. `d_out` shows the pre-write value during that cycle.
- Console FIFO behaviour:
  - A push when full is dropped and sets the sticky overflow bit.
  - A push and a pop in the same cycle while full both succeed and do not set overflow.
  - A read of CONS_STAT clears overflow at that edge. If a dropped push lands in the same edge, set wins.
  - A pop occurs at each edge where `cons_valid`=1 and `cons_ready`=1.
- Cycle counter: 16-bit and increments every cycle while `halt`=0. It wraps at 0xFFFF→0x0000 and freezes once `halt`=1.
- After `halt`, the RAM, CONS_DATA and HALT keep accepting accesses. The console keeps draining.

## Timing
- Reset values: `d_out`=0 while `rd_`=1; `cons_valid`=0; `cons_data`=0; `halt`=0; FIFO empty; overflow=0; counter=0.
- RAM contents are not reset.
- Asserting `rst` mid-operation clears all of the above immediately. A write strobed in the same cycle is discarded.
- Read latency is 0 cycles; data is valid in the same cycle as `rd_`=0.
- Write latency: the value is visible to a read in the cycle after the committing edge.
- Push to `cons_valid`: the first push into an empty FIFO raises `cons_valid` one cycle after the push edge. The FIFO has no fall-through.
- CONS_STAT reflects the count after the previous edge.
- The counter value read in cycle N equals the number of non-halted edges since reset release.

## Structure
- The shared header `minicpu.h` gains the MMIO constants:
  - `MMIO_BASE`, `CONS_DATA_A`, `CONS_STAT_A`, `CYC_LO_A`, `HALT_A`.
  - The status bit positions.
- One sub-module: `console_fifo`, a synchronous FIFO.
  - Parameters: `DATA_W`, `DEPTH`.
  - Signals: push, pop, full, empty, count, head data.
  - Pointers are `$clog2(DEPTH)` wide. The count is `$clog2(DEPTH)+1` bits wide.
- The RAM array, address decode, status, counter and halt logic live in `ram_mmio_responder`.

## Test plan
- RAM round-trip: write 0x5A to 0x10 and 0xA5 to 0xEF, then read both → `d_out` = 0x5A and 0xA5. Reading 0xF3 → 0x00.
- Console ordering: hold `cons_ready`=0 and write 0x41, 0x42, 0x43 to 0xFC. Read 0xFD → 0x30. Raise `cons_ready` → `cons_data` 0x41, 0x42, 0x43 on consecutive cycles, then `cons_valid`=0 and CONS_STAT=0x02.
- Overflow: with `cons_ready`=0, push 5 bytes. CONS_STAT → 0x45; the 5th byte is lost. The next read → 0x41. Push while full with `cons_ready`=1 in the same cycle → no overflow, count stays 4.
- Halt: release reset, wait 10 cycles, read 0xFE → 0x0A. Write 0xFF → `halt`=1 next cycle. CYC_LO stays at its frozen value for 20 more cycles.
- Reset mid-operation: with 3 bytes queued and `halt`=1, pulse `rst` for a partial cycle → `cons_valid`, `halt` and the counter drop to 0 immediately. RAM at 0x10 still reads 0x5A.
- Simultaneous strobes: `rd_`=`wr_`=0 at 0x20 (old value 0x11, `d_in` 0x22) → `d_out`=0x11 that cycle and 0x22 on the next read.
